xc_malu_wb: RTL and testbench
=============================

Name: xc_malu_wb

Overview:
- Writeback sequencer directly downstream of xc_malu.
- Captures the 64-bit malu result when it completes and pulses malu_flush so xc_malu can accept its next operation.
- Drains the captured result to a single-port register-file write interface as one or two 32-bit writes, using a valid/ready handshake toward the writeback arbiter.

Parameters:
- XLEN, 32, width of one register write; the malu result is 2*XLEN bits.
- RD_W, 5, destination register index width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- kill  in  1  pipeline kill; discards any captured or in-flight result.
- malu_valid  in  1  xc_malu inputs valid (mirrors the malu valid input).
- malu_ready  in  1  xc_malu result ready.
- malu_result  in  64  xc_malu result.
- op_rd  in  RD_W  destination register; stable while malu_valid.
- op_wide  in  1  write the full 64-bit result to a register pair (mulu/macc/mmul class).
- op_hi  in  1  single write of result[63:32] (mulh class); ignored if op_wide.
- malu_flush  out  1  flush pulse to xc_malu; result consumed.
- wb_valid  out  1  write request to the register file.
- wb_addr  out  RD_W  write address.
- wb_data  out  XLEN  write data.
- wb_ready  in  1  register file accepts the write this cycle.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset: one clock, synchronous, active-high. All outputs reset to 0, state to IDLE, capture registers to 0.
- States: IDLE, WR_LO, WR_HI.
- Capture event C = malu_valid && malu_ready && state==IDLE && !kill.
- On C:
  - malu_flush=1 combinationally in the same cycle.
  - Latch res_q=malu_result, rd_q=op_rd, wide_q=op_wide, hi_q=op_hi.
  - Next state: WR_LO if op_wide; otherwise WR_HI if op_hi; otherwise WR_LO.
- Write selection:
  - Non-wide, !hi: one write, addr rd_q, data res_q[31:0], issued in WR_LO.
  - Non-wide, hi: one write, addr rd_q, data res_q[63:32], issued in WR_HI.
  - Wide: WR_LO writes {rd_q[4:1],1'b0} with res_q[31:0], then WR_HI writes {rd_q[4:1],1'b1} with res_q[63:32]. op_rd[0] is ignored for wide ops.
- Handshake:
  - wb_valid is high in WR_LO/WR_HI; wb_addr and wb_data are registered and stable while wb_valid && !wb_ready.
  - A write completes on wb_valid && wb_ready.
  - On completion, WR_LO goes to WR_HI if wide_q, else to IDLE. WR_HI goes to IDLE.
- x0 suppression: a write whose address is 0 is never presented. The state advances in one cycle with wb_valid=0.
  - Example: wide with rd_q[4:1]==0 skips the lo write and performs only the x1 write.
- Back-to-back: state returns to IDLE on the final completion. A new capture is possible in the following cycle, so minimum occupancy is 2 cycles per single write and 3 per pair.
- No capture outside IDLE: malu_flush stays 0, so xc_malu holds its result.
- kill:
  - State goes to IDLE next cycle and wb_valid drops immediately (combinational gate). A write coinciding with kill does not complete.
  - malu_flush=1 whenever kill && malu_valid, in any state, so xc_malu state is discarded.
- kill and reset in the same cycle: reset dominates; all registers take reset values.

Optional Feature:
- Macro XC_MALU_WB_BYPASS_EN.
- Defined: for non-wide, non-hi ops in IDLE with C true:
  - wb_valid=1, wb_addr=op_rd, wb_data=malu_result[31:0] are driven combinationally from the inputs.
  - If wb_ready, the write completes, malu_flush=1, and state stays IDLE (one-cycle occupancy).
  - If !wb_ready, the op is captured normally: malu_flush=1 and next state WR_LO.
  - op_rd==0 in bypass completes with wb_valid=0.
- Undefined: no bypass path; behaviour exactly as above.

Decomposition:
- Shared package xc_malu_pkg:
  - State encoding constants (IDLE=2'd0, WR_LO=2'd1, WR_HI=2'd2).
  - XLEN.
  - Register-pair address helper constants.
- Optional sub-module xc_malu_wb_pair: the pure combinational address/data select (pair address formation, half select, x0 suppress), shared with a future load-pair writeback path.
- The FSM and capture registers stay in the top module.

Test Plan:
- Single write: op_rd=5, !wide, !hi, result=64'h1111_2222_3333_4444, wb_ready=1 → malu_flush in capture cycle; next cycle wb_valid with addr 5, data 3333_4444; IDLE after.
- Wide pair with stall: op_rd=7, wide, result=64'hDEAD_BEEF_0123_4567, wb_ready low 3 cycles, then high → addr 6/data 0123_4567 held stable through the stall, then addr 7/data DEAD_BEEF.
- Hi half: op_hi, op_rd=9, result=64'hCAFE_F00D_0000_0001 → single write addr 9, data CAFE_F00D.
- x0 suppression: wide op_rd=0, result=64'hAAAA_AAAA_5555_5555 → no write to 0; one write addr 1, data AAAA_AAAA. !wide rd=0 → no wb_valid; IDLE after one cycle.
- kill in WR_HI of a wide op (with malu_valid=1) → wb_valid drops same cycle, malu_flush=1, IDLE next cycle, no hi write observed.
- Reset asserted in WR_LO with wb_ready=0 → next cycle all outputs 0, state IDLE. With XC_MALU_WB_BYPASS_EN: single write with wb_ready=1 completes in the capture cycle and busy stays 0.

Source files
------------

// File: rtl/xc_malu_pkg.sv
// Shared constants for the xc_malu writeback path: widths, FSM encoding, register-pair halves.
package xc_malu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RD_W  = 5;
    localparam int unsigned RES_W = 2 * XLEN;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR_LO = 2'd1,
        ST_WR_HI = 2'd2
    } wb_state_e;

    // Low bit of a register-pair address selects the half being written.
    localparam logic PAIR_LO = 1'b0;
    localparam logic PAIR_HI = 1'b1;

endpackage

// File: rtl/xc_malu_wb_pair.sv
// Combinational writeback select: pair address formation, result half select, x0 detect.
module xc_malu_wb_pair #(
    parameter int unsigned XLEN = xc_malu_pkg::XLEN,
    parameter int unsigned RD_W = xc_malu_pkg::RD_W
) (
    input  logic [RD_W-1:0]   i_rd,
    input  logic [2*XLEN-1:0] i_res,
    input  logic              i_wide,
    input  logic              i_half,
    output logic [RD_W-1:0]   o_addr,
    output logic [XLEN-1:0]   o_data,
    output logic              o_zero
);

    always_comb begin
        o_addr = i_wide ? {i_rd[RD_W-1:1], i_half} : i_rd;
        o_data = i_half ? i_res[2*XLEN-1:XLEN] : i_res[XLEN-1:0];
        o_zero = (o_addr == '0);
    end

endmodule

// File: rtl/xc_malu_wb.sv
// Writeback sequencer behind xc_malu: captures the 64-bit result, drains it as 1-2 register writes.
// Optional XC_MALU_WB_BYPASS_EN: single low-half writes go straight from the inputs when captured.
module xc_malu_wb #(
    parameter int unsigned XLEN = xc_malu_pkg::XLEN,
    parameter int unsigned RD_W = xc_malu_pkg::RD_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              kill,
    input  logic              malu_valid,
    input  logic              malu_ready,
    input  logic [2*XLEN-1:0] malu_result,
    input  logic [RD_W-1:0]   op_rd,
    input  logic              op_wide,
    input  logic              op_hi,
    output logic              malu_flush,
    output logic              wb_valid,
    output logic [RD_W-1:0]   wb_addr,
    output logic [XLEN-1:0]   wb_data,
    input  logic              wb_ready,
    output logic              busy
);
    import xc_malu_pkg::*;

    wb_state_e         r_state;
    logic [2*XLEN-1:0] r_res;
    logic [RD_W-1:0]   r_rd;
    logic              r_wide;
    logic              r_hi;
    logic              r_wb_vld;
    logic [RD_W-1:0]   r_wb_addr;
    logic [XLEN-1:0]   r_wb_data;

    wb_state_e         w_nxt_state;
    logic [2*XLEN-1:0] w_nxt_res;
    logic [RD_W-1:0]   w_nxt_rd;
    logic              w_nxt_wide;
    logic              w_nxt_hi;
    logic              w_nxt_half;
    logic              w_capture;
    logic              w_bypass;
    logic              w_advance;
    logic [RD_W-1:0]   w_pair_addr;
    logic [XLEN-1:0]   w_pair_data;
    logic              w_pair_zero;

    // Next-state and capture logic; kill always wins over any progress.
    always_comb begin
        w_capture   = malu_valid && malu_ready && (r_state == ST_IDLE) && !kill;
`ifdef XC_MALU_WB_BYPASS_EN
        w_bypass    = w_capture && !op_wide && !op_hi;
`else
        w_bypass    = 1'b0;
`endif
        // A suppressed (x0) write has no valid and advances unconditionally.
        w_advance   = !r_wb_vld || wb_ready;
        w_nxt_state = r_state;
        w_nxt_res   = r_res;
        w_nxt_rd    = r_rd;
        w_nxt_wide  = r_wide;
        w_nxt_hi    = r_hi;

        if (kill) begin
            w_nxt_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_capture) begin
                        w_nxt_res  = malu_result;
                        w_nxt_rd   = op_rd;
                        w_nxt_wide = op_wide;
                        w_nxt_hi   = op_hi;
                        if (op_wide)    w_nxt_state = ST_WR_LO;
                        else if (op_hi) w_nxt_state = ST_WR_HI;
                        else            w_nxt_state = ST_WR_LO;
                        if (w_bypass && (wb_ready || op_rd == '0)) w_nxt_state = ST_IDLE;
                    end
                end
                ST_WR_LO: if (w_advance) w_nxt_state = r_wide ? ST_WR_HI : ST_IDLE;
                ST_WR_HI: if (w_advance) w_nxt_state = ST_IDLE;
                default:  w_nxt_state = ST_IDLE;
            endcase
        end

        w_nxt_half = (w_nxt_state == ST_WR_HI) ? PAIR_HI : PAIR_LO;
    end

    // Write payload for the upcoming state is formed here and registered.
    xc_malu_wb_pair #(
        .XLEN (XLEN),
        .RD_W (RD_W)
    ) u_pair (
        .i_rd   (w_nxt_rd),
        .i_res  (w_nxt_res),
        .i_wide (w_nxt_wide),
        .i_half (w_nxt_half),
        .o_addr (w_pair_addr),
        .o_data (w_pair_data),
        .o_zero (w_pair_zero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_res     <= '0;
            r_rd      <= '0;
            r_wide    <= 1'b0;
            r_hi      <= 1'b0;
            r_wb_vld  <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else begin
            r_state   <= w_nxt_state;
            r_res     <= w_nxt_res;
            r_rd      <= w_nxt_rd;
            r_wide    <= w_nxt_wide;
            r_hi      <= w_nxt_hi;
            r_wb_vld  <= (w_nxt_state != ST_IDLE) && !w_pair_zero;
            r_wb_addr <= (w_nxt_state != ST_IDLE) ? w_pair_addr : '0;
            r_wb_data <= (w_nxt_state != ST_IDLE) ? w_pair_data : '0;
        end
    end

    // Kill gates the registered request in the same cycle so no write completes under it.
    always_comb begin
        malu_flush = w_capture || (kill && malu_valid);
        busy       = (r_state != ST_IDLE);
        if (w_bypass) begin
            wb_valid = (op_rd != '0);
            wb_addr  = op_rd;
            wb_data  = malu_result[XLEN-1:0];
        end else begin
            wb_valid = r_wb_vld && !kill;
            wb_addr  = r_wb_addr;
            wb_data  = r_wb_data;
        end
    end

endmodule

// File: tb/tb_xc_malu_wb.sv
// Directed self-checking bench for xc_malu_wb (expectations follow XC_MALU_WB_BYPASS_EN when defined).
module tb_xc_malu_wb;

    logic        clock = 1'b0;
    logic        reset;
    logic        kill;
    logic        malu_valid;
    logic        malu_ready;
    logic [63:0] malu_result;
    logic [4:0]  op_rd;
    logic        op_wide;
    logic        op_hi;
    logic        malu_flush;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clock = ~clock;

    xc_malu_wb dut (
        .clock       (clock),
        .reset       (reset),
        .kill        (kill),
        .malu_valid  (malu_valid),
        .malu_ready  (malu_ready),
        .malu_result (malu_result),
        .op_rd       (op_rd),
        .op_wide     (op_wide),
        .op_hi       (op_hi),
        .malu_flush  (malu_flush),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .wb_ready    (wb_ready),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic wide, input logic hi, input logic [63:0] res);
        malu_valid  = 1'b1;
        malu_ready  = 1'b1;
        op_rd       = rd;
        op_wide     = wide;
        op_hi       = hi;
        malu_result = res;
    endtask

    task automatic quiet();
        malu_valid = 1'b0;
        malu_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; kill = 1'b0; wb_ready = 1'b0;
        malu_valid = 1'b0; malu_ready = 1'b0; malu_result = '0;
        op_rd = '0; op_wide = 1'b0; op_hi = 1'b0;
        step(); step();
        chk("rst_busy",  busy, 0);
        chk("rst_valid", wb_valid, 0);
        chk("rst_addr",  wb_addr, 0);
        chk("rst_data",  wb_data, 0);
        chk("rst_flush", malu_flush, 0);
        reset = 1'b0;

        // Single low write to x5
        step();
        issue(5'd5, 1'b0, 1'b0, 64'h1111_2222_3333_4444);
        wb_ready = 1'b1;
        #1;
        chk("s_cap_flush", malu_flush, 1);
`ifdef XC_MALU_WB_BYPASS_EN
        chk("s_byp_valid", wb_valid, 1);
        chk("s_byp_addr",  wb_addr, 5);
        chk("s_byp_data",  wb_data, 32'h3333_4444);
        step(); quiet(); #1;
        chk("s_byp_busy",  busy, 0);
        chk("s_byp_idle_valid", wb_valid, 0);
`else
        chk("s_cap_valid", wb_valid, 0);
        step(); quiet(); #1;
        chk("s_wr_valid", wb_valid, 1);
        chk("s_wr_addr",  wb_addr, 5);
        chk("s_wr_data",  wb_data, 32'h3333_4444);
        chk("s_wr_busy",  busy, 1);
        chk("s_wr_flush", malu_flush, 0);
        step(); #1;
        chk("s_end_busy",  busy, 0);
        chk("s_end_valid", wb_valid, 0);
`endif

        // Wide pair to x6/x7 with a three-cycle stall on the low write
        step();
        issue(5'd7, 1'b1, 1'b0, 64'hDEAD_BEEF_0123_4567);
        wb_ready = 1'b0;
        #1;
        chk("w_cap_flush", malu_flush, 1);
        step();
        issue(5'd12, 1'b0, 1'b0, 64'h0);  // new op waiting: must not be flushed
        #1;
        chk("w_noflush",  malu_flush, 0);
        chk("w_lo_valid", wb_valid, 1);
        chk("w_lo_addr",  wb_addr, 6);
        chk("w_lo_data",  wb_data, 32'h0123_4567);
        step(); quiet(); #1;
        chk("w_st2_addr", wb_addr, 6);
        chk("w_st2_data", wb_data, 32'h0123_4567);
        step(); #1;
        chk("w_st3_valid", wb_valid, 1);
        chk("w_st3_addr",  wb_addr, 6);
        step(); wb_ready = 1'b1; #1;
        chk("w_lo_done_addr", wb_addr, 6);
        chk("w_lo_done_data", wb_data, 32'h0123_4567);
        step(); #1;
        chk("w_hi_valid", wb_valid, 1);
        chk("w_hi_addr",  wb_addr, 7);
        chk("w_hi_data",  wb_data, 32'hDEAD_BEEF);
        step(); #1;
        chk("w_end_busy", busy, 0);

        // High half to x9
        step();
        issue(5'd9, 1'b0, 1'b1, 64'hCAFE_F00D_0000_0001);
        #1;
        chk("h_cap_flush", malu_flush, 1);
        step(); quiet(); #1;
        chk("h_valid", wb_valid, 1);
        chk("h_addr",  wb_addr, 9);
        chk("h_data",  wb_data, 32'hCAFE_F00D);
        step(); #1;
        chk("h_end_busy", busy, 0);

        // Wide to x0/x1: low write suppressed
        step();
        issue(5'd0, 1'b1, 1'b0, 64'hAAAA_AAAA_5555_5555);
        #1;
        step(); quiet(); #1;
        chk("z_lo_valid", wb_valid, 0);
        chk("z_lo_busy",  busy, 1);
        step(); #1;
        chk("z_hi_valid", wb_valid, 1);
        chk("z_hi_addr",  wb_addr, 1);
        chk("z_hi_data",  wb_data, 32'hAAAA_AAAA);
        step(); #1;
        chk("z_end_busy", busy, 0);

        // Single write to x0: nothing presented
        step();
        issue(5'd0, 1'b0, 1'b0, 64'h1234_5678_9ABC_DEF0);
        #1;
        chk("z1_cap_flush", malu_flush, 1);
        chk("z1_cap_valid", wb_valid, 0);
        step(); quiet(); #1;
`ifdef XC_MALU_WB_BYPASS_EN
        chk("z1_busy", busy, 0);
`else
        chk("z1_busy",  busy, 1);
        chk("z1_valid", wb_valid, 0);
        step(); #1;
        chk("z1_end_busy", busy, 0);
`endif

        // Kill during the high write of a wide op to x2/x3
        step();
        issue(5'd3, 1'b1, 1'b0, 64'h7777_8888_9999_AAAA);
        #1;
        step(); quiet(); #1;
        chk("k_lo_addr", wb_addr, 2);
        step();
        kill = 1'b1; malu_valid = 1'b1;
        #1;
        chk("k_valid", wb_valid, 0);
        chk("k_flush", malu_flush, 1);
        chk("k_busy",  busy, 1);
        step(); kill = 1'b0; malu_valid = 1'b0; #1;
        chk("k_end_busy",  busy, 0);
        chk("k_end_valid", wb_valid, 0);

        // Reset while stalled in WR_LO
        step();
        issue(5'd11, 1'b1, 1'b0, 64'h0BAD_F00D_FEED_FACE);
        wb_ready = 1'b0;
        #1;
        step(); quiet(); #1;
        chk("r_pre_valid", wb_valid, 1);
        chk("r_pre_addr",  wb_addr, 10);
        reset = 1'b1;
        step(); #1;
        chk("r_busy",  busy, 0);
        chk("r_valid", wb_valid, 0);
        chk("r_addr",  wb_addr, 0);
        chk("r_data",  wb_data, 0);
        chk("r_flush", malu_flush, 0);
        reset = 1'b0;
        step(); step(); #1;
        chk("r_stay_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
